// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared state encoding and line levels for the USB transmit encoder
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } nrzi_tx_state_t;

    localparam logic USB_J = 1'b1;
    localparam logic USB_K = 1'b0;

endpackage

// File: rtl/usb_nrzi_tx_fsm.sv
// rtl/usb_nrzi_tx_fsm.sv - packet sequencing FSM: state register, next state, ready/underrun decode
module usb_nrzi_tx_fsm
    import usb_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           in_last,
    input  logic           stuff_needed,
    input  logic           se0_done,
    output nrzi_tx_state_t state,
    output nrzi_tx_state_t next_state,
    output logic           in_ready,
    output logic           underrun
);

    logic last_pending;
    logic accept;

    // Ready depends on the state register alone, so there is no input-to-ready path.
    assign in_ready = (state == IDLE) || (state == DATA);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_pending <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state    <= next_state;
            underrun <= (state == DATA) && !in_valid;
            if (accept && stuff_needed) begin
                last_pending <= in_last;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    if (stuff_needed) begin
                        next_state = STUFF;
                    end else if (in_last) begin
                        next_state = EOP_SE0;
                    end else begin
                        next_state = DATA;
                    end
                end else if (state == DATA) begin
                    // Starved mid-packet: abort straight into the EOP.
                    next_state = EOP_SE0;
                end
            end
            STUFF:   next_state = last_pending ? EOP_SE0 : DATA;
            EOP_SE0: next_state = se0_done ? EOP_J : EOP_SE0;
            EOP_J:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/usb_nrzi_tx.sv
// rtl/usb_nrzi_tx.sv - USB transmit line encoder: bit stuffing, NRZI and SE0/J end-of-packet
module usb_nrzi_tx
    import usb_pkg::*;
#(
    parameter bit   STUFF_EN       = 1'b1,
    parameter int   STUFF_RUN      = 6,
    parameter logic IDLE_LEVEL     = USB_J,
    parameter int   EOP_SE0_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    output logic out_bit,
    output logic out_se0,
    output logic nrzi_sending,
    output logic underrun
);

    localparam int CW = $clog2(STUFF_RUN + 1);
    localparam int SW = $clog2(EOP_SE0_CYCLES + 1);
    localparam logic [CW-1:0] RUN_M1   = CW'(STUFF_RUN - 1);
    localparam logic [SW-1:0] SE0_LOAD = SW'(EOP_SE0_CYCLES - 1);

    nrzi_tx_state_t state;
    nrzi_tx_state_t next_state;
    logic [CW-1:0]  ones;
    logic [SW-1:0]  se0_cnt;
    logic           accept;
    logic           stuff_needed;
    logic           se0_done;

    assign accept   = in_valid && in_ready;
    assign se0_done = (se0_cnt == '0);

    generate
        if (STUFF_EN) begin : g_stuff
            assign stuff_needed = in_bit && (ones == RUN_M1);
        end else begin : g_no_stuff
            assign stuff_needed = 1'b0;
        end
    endgenerate

    usb_nrzi_tx_fsm u_fsm (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .stuff_needed (stuff_needed),
        .se0_done     (se0_done),
        .state        (state),
        .next_state   (next_state),
        .in_ready     (in_ready),
        .underrun     (underrun)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_bit      <= IDLE_LEVEL;
            out_se0      <= 1'b0;
            nrzi_sending <= 1'b0;
            ones         <= '0;
            se0_cnt      <= '0;
        end else begin
            out_se0      <= (next_state == EOP_SE0);
            nrzi_sending <= (next_state != IDLE);

            // J is restored on EOP_J entry, so the next packet encodes against IDLE_LEVEL.
            if (next_state == EOP_J) begin
                out_bit <= IDLE_LEVEL;
            end else if (state == STUFF) begin
                out_bit <= ~out_bit;
            end else if (accept && !in_bit) begin
                out_bit <= ~out_bit;
            end

            if (state == STUFF || state == EOP_J) begin
                ones <= '0;
            end else if (accept) begin
                ones <= in_bit ? ones + 1'b1 : '0;
            end

            if (next_state == EOP_SE0 && state != EOP_SE0) begin
                se0_cnt <= SE0_LOAD;
            end else if (state == EOP_SE0 && !se0_done) begin
                se0_cnt <= se0_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// tb/tb_usb_nrzi_tx.sv - directed self-checking bench for usb_nrzi_tx
module tb_usb_nrzi_tx;

    logic clock;
    logic reset;
    logic in_bit, in_valid, in_last;
    logic in_ready, out_bit, out_se0, nrzi_sending, underrun;
    logic v_bit, v_valid, v_last;
    logic v_ready, v_out, v_se0, v_sending, v_underrun;

    int checks = 0;
    int failures = 0;

    logic sync_exp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic und_bits [3] = '{1'b0, 1'b1, 1'b0};
    logic und_exp  [3] = '{1'b0, 1'b0, 1'b1};
    logic rst_exp  [3] = '{1'b0, 1'b1, 1'b0};

    usb_nrzi_tx dut (
        .clock        (clock),
        .reset        (reset),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_bit      (out_bit),
        .out_se0      (out_se0),
        .nrzi_sending (nrzi_sending),
        .underrun     (underrun)
    );

    usb_nrzi_tx #(.STUFF_EN(1'b0)) dut_nostuff (
        .clock        (clock),
        .reset        (reset),
        .in_bit       (v_bit),
        .in_valid     (v_valid),
        .in_last      (v_last),
        .in_ready     (v_ready),
        .out_bit      (v_out),
        .out_se0      (v_se0),
        .nrzi_sending (v_sending),
        .underrun     (v_underrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic l);
        in_valid = v;
        in_bit   = b;
        in_last  = l;
    endtask

    task automatic eop_tail(input string tag);
        // Entered in the first SE0 cycle; walks the second SE0, the J and the first IDLE cycle.
        chk({tag, "_se0_1"}, out_se0, 1'b1);
        cyc();
        chk({tag, "_se0_2"}, out_se0, 1'b1);
        cyc();
        chk({tag, "_j_se0"}, out_se0, 1'b0);
        chk({tag, "_j_level"}, out_bit, 1'b1);
        chk({tag, "_j_sending"}, nrzi_sending, 1'b1);
        chk({tag, "_j_ready"}, in_ready, 1'b0);
        cyc();
        chk({tag, "_idle_sending"}, nrzi_sending, 1'b0);
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_level"}, out_bit, 1'b1);
    endtask

    initial begin
        clock   = 1'b0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        v_valid = 1'b0;
        v_bit   = 1'b0;
        v_last  = 1'b0;

        cyc();
        chk("in_reset_out_bit", out_bit, 1'b1);
        cyc();
        reset = 1'b0;
        cyc();
        chk("idle_out_bit", out_bit, 1'b1);
        chk("idle_se0", out_se0, 1'b0);
        chk("idle_sending", nrzi_sending, 1'b0);
        chk("idle_ready", in_ready, 1'b1);
        chk("idle_underrun", underrun, 1'b0);

        // SYNC pattern followed by EOP
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 7), (i == 7));
            cyc();
            chk("sync_bit", out_bit, sync_exp[i]);
            chk("sync_sending", nrzi_sending, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
        eop_tail("sync");

        // seven 1s then a last 0: one stuff bit after the sixth 1
        for (int i = 0; i < 6; i++) begin
            chk("stuff_ready_pre", in_ready, 1'b1);
            drive(1'b1, 1'b1, 1'b0);
            cyc();
            chk("stuff_one", out_bit, 1'b1);
        end
        chk("stuff_ready_low", in_ready, 1'b0);
        chk("stuff_se0_low", out_se0, 1'b0);
        cyc();
        chk("stuff_bit", out_bit, 1'b0);
        chk("stuff_ready_back", in_ready, 1'b1);
        cyc();
        chk("stuff_seventh", out_bit, 1'b0);
        chk("stuff_ready_seventh", in_ready, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        cyc();
        chk("stuff_last_toggle", out_bit, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        eop_tail("stuff");

        // sixth 1 carries in_last: stuff bit still emitted before SE0
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, (i == 5));
            cyc();
            chk("slast_one", out_bit, 1'b1);
        end
        chk("slast_ready_low", in_ready, 1'b0);
        chk("slast_data_not_se0", out_se0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        chk("slast_stuff_bit", out_bit, 1'b0);
        eop_tail("slast");

        // underrun after three accepted bits
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, und_bits[i], 1'b0);
            cyc();
            chk("und_bit", out_bit, und_exp[i]);
            chk("und_no_pulse", underrun, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        chk("und_pulse", underrun, 1'b1);
        chk("und_se0_start", out_se0, 1'b1);
        cyc();
        chk("und_pulse_end", underrun, 1'b0);
        chk("und_se0_2", out_se0, 1'b1);
        cyc();
        chk("und_j_se0", out_se0, 1'b0);
        chk("und_j_level", out_bit, 1'b1);
        cyc();
        chk("und_idle_sending", nrzi_sending, 1'b0);
        chk("und_idle_ready", in_ready, 1'b1);

        // reset during the fourth bit, then a fresh packet from J
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            cyc();
            chk("rst_bit", out_bit, rst_exp[i]);
        end
        drive(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        chk("rst_out_bit", out_bit, 1'b1);
        chk("rst_sending", nrzi_sending, 1'b0);
        chk("rst_se0", out_se0, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        cyc();
        chk("rst_new_first", out_bit, 1'b0);
        chk("rst_new_sending", nrzi_sending, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        cyc();
        chk("rst_new_last", out_bit, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        eop_tail("rst_new");

        // stuffing disabled: eight 1s never stall
        for (int i = 0; i < 8; i++) begin
            chk("nostuff_ready", v_ready, 1'b1);
            v_valid = 1'b1;
            v_bit   = 1'b1;
            v_last  = (i == 7);
            cyc();
            chk("nostuff_bit", v_out, 1'b1);
        end
        v_valid = 1'b0;
        chk("nostuff_se0_1", v_se0, 1'b1);
        cyc();
        chk("nostuff_se0_2", v_se0, 1'b1);
        cyc();
        chk("nostuff_j_se0", v_se0, 1'b0);
        chk("nostuff_j_level", v_out, 1'b1);
        cyc();
        chk("nostuff_idle_sending", v_sending, 1'b0);
        chk("nostuff_idle_ready", v_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
